// File: rtl/multicycle_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multicycle FSM controller sequencing an RV32 datapath
//            (IF/ID/EX/MEM/WB/ERR) with memory ready handshake and timeout.
//            Optional feature macro: ILLEGAL_TRAP_EN (illegal opcode -> ERR).
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic [3:0]  ALUCtrl,
    output logic        loadPC,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        retired,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5
    } state_t;

    localparam logic [6:0] c_op_r   = 7'b0110011;
    localparam logic [6:0] c_op_i   = 7'b0010011;
    localparam logic [6:0] c_op_lw  = 7'b0000011;
    localparam logic [6:0] c_op_sw  = 7'b0100011;
    localparam logic [6:0] c_op_beq = 7'b1100011;

    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_xor = 4'b0101;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_slt = 4'b0111;
    localparam logic [3:0] c_alu_srl = 4'b1000;
    localparam logic [3:0] c_alu_sll = 4'b1001;
    localparam logic [3:0] c_alu_sra = 4'b1010;

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_wait_last =
        (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             zero_q, zero_d;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_f7b5;
    logic       w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_beq;
    logic       w_legal;
    logic       w_imm_op;
    logic [3:0] w_arith_op;
    logic [3:0] w_ex_alu;
    logic       w_unused;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_f7b5   = instr[30];
    assign w_unused = ^{instr[31], instr[29:15], instr[11:7]};

    assign w_is_r   = (w_opcode == c_op_r);
    assign w_is_i   = (w_opcode == c_op_i);
    assign w_is_lw  = (w_opcode == c_op_lw);
    assign w_is_sw  = (w_opcode == c_op_sw);
    assign w_is_beq = (w_opcode == c_op_beq);
    assign w_legal  = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_beq;
    assign w_imm_op = w_is_i | w_is_lw | w_is_sw;

    // funct7[5] selects SUB only for R-type; for shifts it picks SRA in both formats
    always_comb begin
        w_arith_op = c_alu_add;
        case (w_funct3)
            3'b000: w_arith_op = (w_is_r && w_f7b5) ? c_alu_sub : c_alu_add;
            3'b001: w_arith_op = c_alu_sll;
            3'b010: w_arith_op = c_alu_slt;
            3'b011: w_arith_op = c_alu_slt;
            3'b100: w_arith_op = c_alu_xor;
            3'b101: w_arith_op = w_f7b5 ? c_alu_sra : c_alu_srl;
            3'b110: w_arith_op = c_alu_or;
            3'b111: w_arith_op = c_alu_and;
            default: w_arith_op = c_alu_add;
        endcase
    end

    always_comb begin
        w_ex_alu = c_alu_and;
        if (w_is_r || w_is_i) begin
            w_ex_alu = w_arith_op;
        end else if (w_is_lw || w_is_sw) begin
            w_ex_alu = c_alu_add;
        end else if (w_is_beq) begin
            w_ex_alu = c_alu_sub;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            wait_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        zero_d  = zero_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (w_legal) begin
                    state_d = S_EX;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_ERR;
`else
                    state_d = S_WB;
`endif
                end
            end
            S_EX: begin
                state_d = (w_is_lw || w_is_sw) ? S_MEM : S_WB;
                if (w_is_beq) begin
                    zero_d = Zero;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    wait_d  = '0;
                    state_d = w_is_sw ? S_IF : S_WB;
                end else if (MEM_TIMEOUT != 0) begin
                    // Counter ends parked at MEM_TIMEOUT; only rst clears it from ERR
                    wait_d = wait_q + 1'b1;
                    if (wait_q == c_wait_last) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WB:    state_d = S_IF;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IF;
        endcase
    end

    // Outputs are forced idle while rst is high so an aborted instruction never commits
    always_comb begin
        PCSrc    = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        ALUCtrl  = c_alu_and;
        loadPC   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        retired  = 1'b0;
        err      = 1'b0;
        if (!rst) begin
            case (state_q)
                S_EX: begin
                    ALUSrc  = w_imm_op;
                    ALUCtrl = w_ex_alu;
                end
                S_MEM: begin
                    ALUSrc   = w_imm_op;
                    ALUCtrl  = w_ex_alu;
                    MemRead  = w_is_lw;
                    MemWrite = w_is_sw;
                    if (w_is_sw && mem_ready) begin
                        loadPC  = 1'b1;
                        retired = 1'b1;
                    end
                end
                S_WB: begin
                    ALUSrc   = w_imm_op;
                    ALUCtrl  = w_ex_alu;
                    RegWrite = w_is_r | w_is_i | w_is_lw;
                    MemToReg = w_is_lw;
                    PCSrc    = w_is_beq & zero_q;
                    loadPC   = 1'b1;
                    retired  = 1'b1;
                end
                S_ERR:   err = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed cycle-by-cycle scoreboard bench for multicycle_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic        mem_ready;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg;
    logic [3:0]  ALUCtrl;
    logic        loadPC, MemRead, MemWrite, retired, err;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_q[$];
    string       tag_q[$];
    logic [12:0] obs;

    localparam logic [12:0] IDLE = 13'd0;
    localparam logic [3:0]  ADD  = 4'b0010;
    localparam logic [3:0]  SUB  = 4'b0110;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .PCSrc     (PCSrc),
        .ALUSrc    (ALUSrc),
        .RegWrite  (RegWrite),
        .MemToReg  (MemToReg),
        .ALUCtrl   (ALUCtrl),
        .loadPC    (loadPC),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .retired   (retired),
        .err       (err)
    );

    assign obs = {PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl,
                  loadPC, MemRead, MemWrite, retired, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [12:0] ev(input logic pcs, input logic als,
                                       input logic rw, input logic mtr,
                                       input logic [3:0] alu, input logic lpc,
                                       input logic mrd, input logic mwr,
                                       input logic ret, input logic er);
        return {pcs, als, rw, mtr, alu, lpc, mrd, mwr, ret, er};
    endfunction

    task automatic check_out();
        logic [12:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic rdy,
                        input logic z, input logic [12:0] e);
        rst = r;
        mem_ready = rdy;
        Zero = z;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic nocheck(input logic r);
        rst = r;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ri_instr [9] = '{32'h00208133, 32'h402081B3, 32'h40005033,
                                  32'h00006033, 32'h00002013, 32'h00005013,
                                  32'h00004013, 32'h00007013, 32'h00001013};
    logic        ri_als   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                  1'b1, 1'b1, 1'b1};
    logic [3:0]  ri_alu   [9] = '{4'b0010, 4'b0110, 4'b1010, 4'b0001, 4'b0111,
                                  4'b1000, 4'b0101, 4'b0000, 4'b1001};

    initial begin
        rst = 1'b1;
        instr = 32'h0;
        Zero = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step("reset", 1, 0, 0, IDLE);

        // ADDI x1,x0,5 with stray mem_ready outside MEM
        instr = 32'h00500093;
        step("addi_if", 0, 1, 0, IDLE);
        step("addi_id", 0, 1, 0, IDLE);
        step("addi_ex", 0, 1, 0, ev(0, 1, 0, 0, ADD, 0, 0, 0, 0, 0));
        step("addi_wb", 0, 1, 0, ev(0, 1, 1, 0, ADD, 1, 0, 0, 1, 0));

        for (int i = 0; i < 9; i++) begin
            instr = ri_instr[i];
            step($sformatf("ri%0d_if", i), 0, 0, 0, IDLE);
            step($sformatf("ri%0d_id", i), 0, 0, 0, IDLE);
            step($sformatf("ri%0d_ex", i), 0, 0, 0,
                 ev(0, ri_als[i], 0, 0, ri_alu[i], 0, 0, 0, 0, 0));
            step($sformatf("ri%0d_wb", i), 0, 0, 0,
                 ev(0, ri_als[i], 1, 0, ri_alu[i], 1, 0, 0, 1, 0));
        end

        // LW with three wait cycles
        instr = 32'h00002083;
        step("lw_if", 0, 0, 0, IDLE);
        step("lw_id", 0, 0, 0, IDLE);
        step("lw_ex", 0, 1, 0, ev(0, 1, 0, 0, ADD, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            step($sformatf("lw_wait%0d", i), 0, 0, 0, ev(0, 1, 0, 0, ADD, 0, 1, 0, 0, 0));
        step("lw_mem_rdy", 0, 1, 0, ev(0, 1, 0, 0, ADD, 0, 1, 0, 0, 0));
        step("lw_wb", 0, 0, 0, ev(0, 1, 1, 1, ADD, 1, 0, 0, 1, 0));

        // SW with immediate ready, then SW with one wait
        instr = 32'h00102023;
        step("sw_if", 0, 0, 0, IDLE);
        step("sw_id", 0, 0, 0, IDLE);
        step("sw_ex", 0, 0, 0, ev(0, 1, 0, 0, ADD, 0, 0, 0, 0, 0));
        step("sw_mem", 0, 1, 0, ev(0, 1, 0, 0, ADD, 1, 0, 1, 1, 0));
        step("sw2_if", 0, 0, 0, IDLE);
        step("sw2_id", 0, 0, 0, IDLE);
        step("sw2_ex", 0, 0, 0, ev(0, 1, 0, 0, ADD, 0, 0, 0, 0, 0));
        step("sw2_wait", 0, 0, 0, ev(0, 1, 0, 0, ADD, 0, 0, 1, 0, 0));
        step("sw2_mem", 0, 1, 0, ev(0, 1, 0, 0, ADD, 1, 0, 1, 1, 0));

        // BEQ: Zero sampled in EX, later changes must not matter
        instr = 32'h00000063;
        step("beq1_if", 0, 0, 0, IDLE);
        step("beq1_id", 0, 0, 0, IDLE);
        step("beq1_ex", 0, 0, 1, ev(0, 0, 0, 0, SUB, 0, 0, 0, 0, 0));
        step("beq1_wb", 0, 0, 0, ev(1, 0, 0, 0, SUB, 1, 0, 0, 1, 0));
        step("beq0_if", 0, 0, 1, IDLE);
        step("beq0_id", 0, 0, 1, IDLE);
        step("beq0_ex", 0, 0, 0, ev(0, 0, 0, 0, SUB, 0, 0, 0, 0, 0));
        step("beq0_wb", 0, 0, 1, ev(0, 0, 0, 0, SUB, 1, 0, 0, 1, 0));

        // rst during EX, then a clean ADDI
        instr = 32'h00500093;
        step("rstex_if", 0, 0, 0, IDLE);
        step("rstex_id", 0, 0, 0, IDLE);
        step("rstex_ex", 1, 0, 0, IDLE);
        step("rstex_if2", 0, 0, 0, IDLE);
        step("rstex_id2", 0, 0, 0, IDLE);
        step("rstex_ex2", 0, 0, 0, ev(0, 1, 0, 0, ADD, 0, 0, 0, 0, 0));
        step("rstex_wb2", 0, 0, 0, ev(0, 1, 1, 0, ADD, 1, 0, 0, 1, 0));

        // rst in the WB cycle suppresses the commit
        step("rstwb_if", 0, 0, 0, IDLE);
        step("rstwb_id", 0, 0, 0, IDLE);
        step("rstwb_ex", 0, 0, 0, ev(0, 1, 0, 0, ADD, 0, 0, 0, 0, 0));
        step("rstwb_wb", 1, 0, 0, IDLE);
        step("rstwb_after", 0, 0, 0, IDLE);

        // Unrecognised opcode 0x7F; the previous step left the FSM in ID
        instr = 32'h0000007F;
        step("ill_if", 1, 0, 0, IDLE);
        step("ill_if2", 0, 0, 0, IDLE);
        step("ill_id", 0, 0, 0, IDLE);
`ifdef ILLEGAL_TRAP_EN
        step("ill_err0", 0, 1, 0, ev(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
        step("ill_err1", 0, 0, 0, ev(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
        nocheck(1);
`else
        step("ill_wb", 0, 0, 0, ev(0, 0, 0, 0, 4'b0000, 1, 0, 0, 1, 0));
`endif
        step("ill_next_if", 0, 0, 0, IDLE);

        // LW with mem_ready stuck low: 16 MEM cycles, then sticky ERR
        instr = 32'h00002083;
        step("to_id", 0, 0, 0, IDLE);
        step("to_ex", 0, 0, 0, ev(0, 1, 0, 0, ADD, 0, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++)
            step($sformatf("to_mem%0d", i), 0, 0, 0, ev(0, 1, 0, 0, ADD, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            step($sformatf("to_err%0d", i), 0, 1, 0, ev(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
        nocheck(1);
        instr = 32'h00500093;
        step("to_rec_if", 0, 0, 0, IDLE);
        step("to_rec_id", 0, 0, 0, IDLE);
        step("to_rec_ex", 0, 0, 0, ev(0, 1, 0, 0, ADD, 0, 0, 0, 0, 0));
        step("to_rec_wb", 0, 0, 0, ev(0, 1, 1, 0, ADD, 1, 0, 0, 1, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
